// File: rtl/frame_crc_checker.sv
// Store-and-forward CRC-8 frame checker: forwards a frame (minus its CRC byte) only when the CRC matches.
// Optional macro FRAME_CRC_STATS_EN adds saturating good_count/bad_count outputs.
module frame_crc_checker #(
    parameter int unsigned DEPTH_LOG2 = 9,
    parameter logic [7:0]  CRC_POLY   = 8'h07
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        target_tvalid,
    output logic        target_tready,
    input  logic [7:0]  target_tdata,
    input  logic        target_tlast,
    output logic        initiator_tvalid,
    input  logic        initiator_tready,
    output logic [7:0]  initiator_tdata,
    output logic        initiator_tlast,
    output logic        crc_err_pulse,
    output logic        runt_pulse,
    output logic        overflow_pulse
`ifdef FRAME_CRC_STATS_EN
    ,
    output logic [15:0] good_count,
    output logic [15:0] bad_count
`endif
);

    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RECV = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    // MSB-first CRC-8 update over one byte, no reflection
    function automatic logic [7:0] crc8_update(input logic [7:0] crc_in, input logic [7:0] data);
        logic [7:0] c;
        c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [7:0]       stage_q, stage_d;
    logic [7:0]       crc_q, crc_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] wr_commit_q, wr_commit_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic             tready_q;
    logic             crc_err_q, crc_err_d;
    logic             runt_q, runt_d;
    logic             ovf_q, ovf_d;

    logic [8:0]       mem_q [DEPTH];
    logic [8:0]       rd_data_q;
    logic             rd_valid_q;
    logic             out_valid_q;
    logic [7:0]       out_data_q;
    logic             out_last_q;

    logic             beat_c;
    logic             full_c;
    logic             wr_en_c;
    logic             wr_last_c;
    logic             out_load_c;
    logic             rd_advance_c;
    logic             rd_issue_c;

    assign beat_c = target_tvalid && tready_q && !areset;
    // Free space is judged against the registered read pointer, so it can lag by one byte
    assign full_c = (wr_ptr_q - rd_ptr_q) == DEPTH_P;

    // Receive FSM: stages one byte so the byte before the CRC can be written with last=1
    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        crc_d       = crc_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        wr_en_c     = 1'b0;
        wr_last_c   = 1'b0;
        crc_err_d   = 1'b0;
        runt_d      = 1'b0;
        ovf_d       = 1'b0;
        if (beat_c) begin
            case (state_q)
                S_IDLE: begin
                    if (target_tlast) begin
                        runt_d = 1'b1;
                    end else begin
                        stage_d = target_tdata;
                        crc_d   = crc8_update(8'h00, target_tdata);
                        state_d = S_RECV;
                    end
                end
                S_RECV: begin
                    if (full_c) begin
                        ovf_d    = 1'b1;
                        wr_ptr_d = wr_commit_q;
                        state_d  = target_tlast ? S_IDLE : S_DROP;
                    end else if (!target_tlast) begin
                        wr_en_c  = 1'b1;
                        wr_ptr_d = wr_ptr_q + ONE_P;
                        stage_d  = target_tdata;
                        crc_d    = crc8_update(crc_q, target_tdata);
                    end else if (crc_q == target_tdata) begin
                        wr_en_c     = 1'b1;
                        wr_last_c   = 1'b1;
                        wr_ptr_d    = wr_ptr_q + ONE_P;
                        wr_commit_d = wr_ptr_q + ONE_P;
                        state_d     = S_IDLE;
                    end else begin
                        crc_err_d = 1'b1;
                        wr_ptr_d  = wr_commit_q;
                        state_d   = S_IDLE;
                    end
                end
                S_DROP: begin
                    if (target_tlast) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Read pipeline: registered memory read stage feeding the output register
    assign out_load_c   = !out_valid_q || initiator_tready;
    assign rd_advance_c = rd_valid_q && out_load_c;
    assign rd_issue_c   = (rd_ptr_q != wr_commit_q) && (!rd_valid_q || out_load_c);

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= S_IDLE;
            stage_q     <= '0;
            crc_q       <= '0;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            tready_q    <= 1'b0;
            crc_err_q   <= 1'b0;
            runt_q      <= 1'b0;
            ovf_q       <= 1'b0;
            rd_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            crc_q       <= crc_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            tready_q    <= 1'b1;
            crc_err_q   <= crc_err_d;
            runt_q      <= runt_d;
            ovf_q       <= ovf_d;
            if (rd_issue_c) begin
                rd_ptr_q <= rd_ptr_q + ONE_P;
            end
            if (rd_issue_c) begin
                rd_valid_q <= 1'b1;
            end else if (rd_advance_c) begin
                rd_valid_q <= 1'b0;
            end
            if (out_load_c) begin
                out_valid_q <= rd_valid_q;
            end
            if (rd_advance_c) begin
                out_data_q <= rd_data_q[7:0];
                out_last_q <= rd_data_q[8];
            end
        end
    end

    // Buffer storage; no reset so it maps onto a plain RAM
    always_ff @(posedge aclk) begin
        if (wr_en_c) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= {wr_last_c, stage_q};
        end
    end

    always_ff @(posedge aclk) begin
        if (rd_issue_c) begin
            rd_data_q <= mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
        end
    end

    assign target_tready    = tready_q;
    assign initiator_tvalid = out_valid_q;
    assign initiator_tdata  = out_data_q;
    assign initiator_tlast  = out_last_q;
    assign crc_err_pulse    = crc_err_q;
    assign runt_pulse       = runt_q;
    assign overflow_pulse   = ovf_q;

`ifdef FRAME_CRC_STATS_EN
    logic [15:0] good_cnt_q;
    logic [15:0] bad_cnt_q;
    logic        good_inc_c;
    logic        bad_inc_c;

    assign good_inc_c = (wr_commit_d != wr_commit_q);
    assign bad_inc_c  = crc_err_d || runt_d || ovf_d;

    // Saturating frame counters
    always_ff @(posedge aclk) begin
        if (areset) begin
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
        end else begin
            if (good_inc_c && (good_cnt_q != 16'hFFFF)) begin
                good_cnt_q <= good_cnt_q + 16'd1;
            end
            if (bad_inc_c && (bad_cnt_q != 16'hFFFF)) begin
                bad_cnt_q <= bad_cnt_q + 16'd1;
            end
        end
    end

    assign good_count = good_cnt_q;
    assign bad_count  = bad_cnt_q;
`endif

endmodule

// File: tb/tb_frame_crc_checker.sv
// Scoreboard bench for frame_crc_checker: a frame-level reference model predicts forwarded bytes and drop pulses.
module tb_frame_crc_checker;

    localparam int unsigned DL2   = 4;
    localparam int unsigned DEPTH = 1 << DL2;

    typedef logic [7:0] byte_q_t[$];

    logic       aclk = 1'b0;
    logic       areset;
    logic       target_tvalid;
    logic       target_tready;
    logic [7:0] target_tdata;
    logic       target_tlast;
    logic       initiator_tvalid;
    logic       initiator_tready;
    logic [7:0] initiator_tdata;
    logic       initiator_tlast;
    logic       crc_err_pulse;
    logic       runt_pulse;
    logic       overflow_pulse;
`ifdef FRAME_CRC_STATS_EN
    logic [15:0] good_count;
    logic [15:0] bad_count;
`endif

    frame_crc_checker #(.DEPTH_LOG2(DL2), .CRC_POLY(8'h07)) dut (
        .aclk             (aclk),
        .areset           (areset),
        .target_tvalid    (target_tvalid),
        .target_tready    (target_tready),
        .target_tdata     (target_tdata),
        .target_tlast     (target_tlast),
        .initiator_tvalid (initiator_tvalid),
        .initiator_tready (initiator_tready),
        .initiator_tdata  (initiator_tdata),
        .initiator_tlast  (initiator_tlast),
        .crc_err_pulse    (crc_err_pulse),
        .runt_pulse       (runt_pulse),
        .overflow_pulse   (overflow_pulse)
`ifdef FRAME_CRC_STATS_EN
        ,
        .good_count       (good_count),
        .bad_count        (bad_count)
`endif
    );

    always #5 aclk = ~aclk;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];
    int         exp_crc = 0, exp_runt = 0, exp_ovf = 0;
    int         obs_crc = 0, obs_runt = 0, obs_ovf = 0;
    int         exp_good = 0, exp_bad = 0;
    int         rdy_mode = 0;
    logic       rdy_phase = 1'b0;
    logic       held_v = 1'b0;
    logic [8:0] held_b = '0;
    logic [8:0] mon_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference CRC: bit-serial polynomial division of the message, MSB first
    function automatic logic [7:0] crc_ref(input byte_q_t msg);
        logic [7:0] r;
        logic       fb;
        r = 8'h00;
        foreach (msg[k]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = r[7] ^ msg[k][b];
                r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return r;
    endfunction

    // Sink readiness: 0 always, 1 never, 2 alternating, 3 random
    initial begin
        initiator_tready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            case (rdy_mode)
                0: initiator_tready = 1'b1;
                1: initiator_tready = 1'b0;
                2: begin
                    rdy_phase        = ~rdy_phase;
                    initiator_tready = rdy_phase;
                end
                default: initiator_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on each output handshake, counts pulses, checks stall stability
    always @(negedge aclk) begin
        if (areset) begin
            held_v = 1'b0;
        end else begin
            if (crc_err_pulse)  obs_crc++;
            if (runt_pulse)     obs_runt++;
            if (overflow_pulse) obs_ovf++;
            if (held_v) begin
                chk("stall_hold", 32'({initiator_tvalid, initiator_tlast, initiator_tdata}), 32'({1'b1, held_b}));
            end
            held_v = initiator_tvalid && !initiator_tready;
            held_b = {initiator_tlast, initiator_tdata};
            if (initiator_tvalid && initiator_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%0h expected=none at %0t", {initiator_tlast, initiator_tdata}, $time);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("out_beat", 32'({initiator_tlast, initiator_tdata}), 32'(mon_exp));
                end
            end
        end
    end

    task automatic send_beat(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        @(negedge aclk);
        target_tvalid = 1'b1;
        target_tdata  = d;
        target_tlast  = l;
        while (!target_tready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        if (!target_tready) chk("tready_timeout", 32'(target_tready), 32'd1);
        @(posedge aclk);
    endtask

    task automatic predict(input byte_q_t data, input logic [7:0] crc_b);
        if (data.size() == 0) begin
            exp_runt++;
            exp_bad++;
        end else if (data.size() > DEPTH) begin
            exp_ovf++;
            exp_bad++;
        end else if (crc_ref(data) == crc_b) begin
            foreach (data[k]) exp_q.push_back({(k == data.size() - 1), data[k]});
            exp_good++;
        end else begin
            exp_crc++;
            exp_bad++;
        end
    endtask

    task automatic send_frame(input byte_q_t data, input logic [7:0] crc_b, input bit b2b);
        foreach (data[k]) send_beat(data[k], 1'b0);
        send_beat(crc_b, 1'b1);
        predict(data, crc_b);
        if (!b2b) begin
            @(negedge aclk);
            target_tvalid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        @(negedge aclk);
        target_tvalid = 1'b0;
        repeat (n) @(negedge aclk);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || initiator_tvalid) && n < 3000) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 3000) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_pulses(input string tag);
        idle(3);
        chk({tag, "_crc_err"}, 32'(obs_crc), 32'(exp_crc));
        chk({tag, "_runt"}, 32'(obs_runt), 32'(exp_runt));
        chk({tag, "_overflow"}, 32'(obs_ovf), 32'(exp_ovf));
    endtask

    task automatic do_reset();
        @(negedge aclk);
        target_tvalid = 1'b0;
        @(posedge aclk);
        #1;
        areset = 1'b1;
        exp_q.delete();
        @(posedge aclk);
        #1;
        chk("rst_tvalid", 32'(initiator_tvalid), 32'd0);
        chk("rst_tready", 32'(target_tready), 32'd0);
        chk("rst_pulses", 32'({crc_err_pulse, runt_pulse, overflow_pulse}), 32'd0);
`ifdef FRAME_CRC_STATS_EN
        chk("rst_good_count", 32'(good_count), 32'd0);
        chk("rst_bad_count", 32'(bad_count), 32'd0);
`endif
        exp_good = 0;
        exp_bad  = 0;
        areset   = 1'b0;
        @(posedge aclk);
        #1;
        chk("post_rst_tready", 32'(target_tready), 32'd1);
    endtask

    byte_q_t     q;
    byte_q_t     q2;
    logic [7:0]  c;
    int unsigned len;
    bit          bad;
    bit          b2b;
    int          n;

    initial begin
        areset        = 1'b1;
        target_tvalid = 1'b0;
        target_tdata  = '0;
        target_tlast  = 1'b0;
        do_reset();

        // Good frame "123456789" + F4, latency check
        rdy_mode = 0;
        q.delete();
        for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
        send_frame(q, 8'hF4, 1'b0);
        chk("lat_cycle1", 32'(initiator_tvalid), 32'd0);
        @(negedge aclk);
        chk("lat_cycle2", 32'(initiator_tvalid), 32'd0);
        @(negedge aclk);
        chk("lat_cycle3", 32'(initiator_tvalid), 32'd1);
        chk("first_byte", 32'({initiator_tlast, initiator_tdata}), 32'({1'b0, 8'h31}));
        wait_drain();
        check_pulses("good");

        // Bad CRC then a good 01 02 / 1B frame
        send_frame(q, 8'hF5, 1'b0);
        q.delete();
        q.push_back(8'h01);
        q.push_back(8'h02);
        send_frame(q, 8'h1B, 1'b0);
        wait_drain();
        check_pulses("badcrc");

        // Runt
        q.delete();
        send_frame(q, 8'h55, 1'b0);
        wait_drain();
        check_pulses("runt");

        // Overflow: drop inside frame, drop at CRC beat, then small frame alone, then exact fit
        rdy_mode = 1;
        q.delete();
        for (int i = 0; i < 20; i++) q.push_back(8'($urandom_range(0, 255)));
        send_frame(q, crc_ref(q), 1'b0);
        q.delete();
        for (int i = 0; i < 17; i++) q.push_back(8'($urandom_range(0, 255)));
        send_frame(q, crc_ref(q), 1'b0);
        idle(4);
        chk("ovf_nothing_buffered", 32'(initiator_tvalid), 32'd0);
        q.delete();
        q.push_back(8'hA1);
        q.push_back(8'hA2);
        q.push_back(8'hA3);
        send_frame(q, crc_ref(q), 1'b0);
        idle(4);
        rdy_mode = 0;
        wait_drain();
        rdy_mode = 1;
        q.delete();
        for (int i = 0; i < 16; i++) q.push_back(8'(8'hC0 + 8'(i)));
        send_frame(q, crc_ref(q), 1'b0);
        idle(4);
        rdy_mode = 0;
        wait_drain();
        check_pulses("overflow");

        // Backpressure: three back-to-back frames, 1010 ready pattern
        rdy_mode = 2;
        q.delete();
        for (int i = 0; i < 5; i++) q.push_back(8'($urandom_range(0, 255)));
        send_frame(q, crc_ref(q), 1'b1);
        q.delete();
        q.push_back(8'h7E);
        send_frame(q, crc_ref(q), 1'b1);
        q.delete();
        for (int i = 0; i < 7; i++) q.push_back(8'($urandom_range(0, 255)));
        send_frame(q, crc_ref(q), 1'b0);
        wait_drain();
        rdy_mode = 0;
        check_pulses("backpressure");

        // Reset while output is stalled-valid and a frame is half received
        rdy_mode = 1;
        q.delete();
        for (int i = 0; i < 4; i++) q.push_back(8'(8'h10 + 8'(i)));
        send_frame(q, crc_ref(q), 1'b0);
        idle(4);
        chk("pre_reset_valid", 32'(initiator_tvalid), 32'd1);
        q.delete();
        for (int i = 0; i < 5; i++) q.push_back(8'(8'h60 + 8'(i)));
        send_beat(q[0], 1'b0);
        send_beat(q[1], 1'b0);
        send_beat(q[2], 1'b0);
        do_reset();
        rdy_mode = 0;
        q2.delete();
        q2.push_back(q[3]);
        q2.push_back(q[4]);
        send_frame(q2, crc_ref(q), 1'b0);
        q.delete();
        for (int i = 0; i < 6; i++) q.push_back(8'($urandom_range(0, 255)));
        send_frame(q, crc_ref(q), 1'b0);
        wait_drain();
        check_pulses("reset");

        // Random frames: mixed lengths, CRC errors, runts, random sink readiness
        rdy_mode = 3;
        for (int f = 0; f < 60; f++) begin
            len = $urandom_range(0, 8);
            bad = ($urandom_range(0, 3) == 0);
            b2b = 1'($urandom_range(0, 1));
            q.delete();
            for (int i = 0; i < int'(len); i++) q.push_back(8'($urandom_range(0, 255)));
            c = crc_ref(q);
            if (bad) c = c ^ 8'($urandom_range(1, 255));
            if (exp_q.size() + int'(len) > int'(DEPTH)) begin
                @(negedge aclk);
                target_tvalid = 1'b0;
                n = 0;
                while (exp_q.size() + int'(len) > int'(DEPTH) && n < 3000) begin
                    @(negedge aclk);
                    n++;
                end
                if (n >= 3000) chk("space_timeout", 32'(exp_q.size()), 32'd0);
            end
            send_frame(q, c, b2b);
            if (!b2b) idle($urandom_range(0, 2));
        end
        idle(2);
        rdy_mode = 0;
        wait_drain();
        check_pulses("random");
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
`ifdef FRAME_CRC_STATS_EN
        chk("good_count", 32'(good_count), 32'(exp_good));
        chk("bad_count", 32'(bad_count), 32'(exp_bad));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
